fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory and fills the IF/ID register.
//  if_opcode drives the decode/control unit's 4-bit inst input.

---
 rtl/fetch_stage_pkg.sv | 35 +++
 rtl/fetch_hold_buf.sv | 61 ++++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the instruction-fetch stage.
//   - opcode encodings seen in the top 4 bits of an instruction word
//   - opcode field position for the default 16-bit instruction
//   - fetch FSM state encodings
package fetch_stage_pkg;

    // Opcode field position for a 16-bit instruction word.
    localparam int unsigned OpcHi = 15;
    localparam int unsigned OpcLo = 12;
    localparam int unsigned OpcW  = OpcHi - OpcLo + 1;

    typedef enum logic [OpcW-1:0] {
        OpAdd = 4'h0,
        OpSub = 4'h1,
        OpAnd = 4'h2,
        OpOr  = 4'h3,
        OpXor = 4'h4,
        OpSll = 4'h5,
        OpSrl = 4'h6,
        OpMul = 4'h7,
        OpLw  = 4'h8,
        OpSw  = 4'h9,
        OpBeq = 4'hA,
        OpJ   = 4'hB,
        OpJal = 4'hC,
        OpJr  = 4'hD
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry skid register parking a fetched {inst, pc_plus1}
// while decode is stalled.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_i              capture inst_i / pc_plus1_i, mark valid
//   drain_i             entry consumed, mark empty
//   clear_i             discard entry (redirect); wins over load/drain
//   inst_i, pc_plus1_i  entry to park
//   valid_o, inst_o, pc_plus1_o  parked entry
module fetch_hold_buf #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned INST_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_plus1_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_plus1_o
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_plus1_q, pc_plus1_d;

    always_comb begin
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_plus1_d = pc_plus1_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d    = 1'b1;
            inst_d     = inst_i;
            pc_plus1_d = pc_plus1_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_plus1_q <= '0;
        end else begin
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_plus1_q <= pc_plus1_d;
        end
    end

    assign valid_o    = valid_q;
    assign inst_o     = inst_q;
    assign pc_plus1_o = pc_plus1_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues instruction-memory requests and fills the
// IF/ID register. Handles hazard stalls (via a one-entry hold buffer) and
// redirects from the branch/jump resolving stage.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   imem_req_o, imem_addr_o      fetch request / word address
//   imem_ready_i, imem_rdata_i   request accepted, instruction word
//   stall_i                      hold IF/ID (hazard)
//   redirect_valid_i/pc_i        one-cycle pulse: resume fetch at target
//   if_valid_o, if_inst_o        IF/ID contents
//   if_opcode_o                  top 4 bits of if_inst_o
//   if_pc_plus1_o                PC of if_inst_o + 1
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              if_valid_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic [OpcW-1:0]   if_opcode_o,
    output logic [PC_W-1:0]   if_pc_plus1_o
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_plus1;
    // Address of the request being dropped; keeps imem_addr stable in StDrop.
    logic [PC_W-1:0]   drop_addr_q, drop_addr_d;
    logic              if_valid_q, if_valid_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [PC_W-1:0]   if_pc_plus1_q, if_pc_plus1_d;

    logic              hold_valid, hold_load, hold_drain, hold_clear;
    logic [INST_W-1:0] hold_inst;
    logic [PC_W-1:0]   hold_pc_plus1;

    logic              imem_req, accept, fetch_ok;

    assign pc_plus1 = pc_q + PC_W'(1);

    always_comb begin
        case (state_q)
            StReq:   imem_req = !hold_valid;
            StDrop:  imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    assign accept   = imem_req && imem_ready_i;
    // Only accepts in StReq deliver a live instruction.
    assign fetch_ok = accept && (state_q == StReq);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        if_valid_d    = if_valid_q;
        if_inst_d     = if_inst_q;
        if_pc_plus1_d = if_pc_plus1_q;
        hold_load     = 1'b0;
        hold_drain    = 1'b0;
        hold_clear    = 1'b0;

        if (redirect_valid_i) begin
            pc_d       = redirect_pc_i;
            if_valid_d = 1'b0;
            hold_clear = 1'b1;
            if (imem_req && !imem_ready_i) begin
                state_d = StDrop;
                if (state_q != StDrop) begin
                    drop_addr_d = pc_q;
                end
            end else begin
                state_d = StReq;
            end
        end else begin
            case (state_q)
                StIdle:  state_d = StReq;
                StReq:   if (accept) pc_d = pc_plus1;
                StDrop:  if (accept) state_d = StReq;
                default: state_d = StIdle;
            endcase

            if (!stall_i) begin
                if (hold_valid) begin
                    if_valid_d    = 1'b1;
                    if_inst_d     = hold_inst;
                    if_pc_plus1_d = hold_pc_plus1;
                    hold_drain    = 1'b1;
                end else if (fetch_ok) begin
                    if_valid_d    = 1'b1;
                    if_inst_d     = imem_rdata_i;
                    if_pc_plus1_d = pc_plus1;
                end else begin
                    if_valid_d = 1'b0;
                end
            end else if (fetch_ok) begin
                // Park even when IF/ID is empty so an accepted word is never lost.
                hold_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            drop_addr_q   <= '0;
            if_valid_q    <= 1'b0;
            if_inst_q     <= '0;
            if_pc_plus1_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            if_valid_q    <= if_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc_plus1_q <= if_pc_plus1_d;
        end
    end

    fetch_hold_buf #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_hold_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (hold_load),
        .drain_i    (hold_drain),
        .clear_i    (hold_clear),
        .inst_i     (imem_rdata_i),
        .pc_plus1_i (pc_plus1),
        .valid_o    (hold_valid),
        .inst_o     (hold_inst),
        .pc_plus1_o (hold_pc_plus1)
    );

    assign imem_req_o    = imem_req;
    assign imem_addr_o   = (state_q == StDrop) ? drop_addr_q : pc_q;
    assign if_valid_o    = if_valid_q;
    assign if_inst_o     = if_inst_q;
    assign if_opcode_o   = if_inst_q[INST_W-1 -: OpcW];
    assign if_pc_plus1_o = if_pc_plus1_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle-scripted bench for fetch_stage. Memory returns
// inst = addr. A scoreboard queue holds the expected instruction addresses
// in program order; a monitor pops one whenever decode consumes IF/ID
// (if_valid && !stall) and checks inst, pc+1 and opcode.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        stall;
    logic        redir;
    logic [15:0] redir_pc;

    logic        imem_req, if_valid;
    logic [15:0] imem_addr, imem_rdata, if_inst, if_pc_plus1;
    logic [3:0]  if_opcode;

    logic        b_imem_req, b_if_valid;
    logic [15:0] b_imem_addr, b_imem_rdata, b_if_inst, b_if_pc_plus1;
    logic [3:0]  b_if_opcode;

    int unsigned n_vec = 0;
    int unsigned n_miscmp = 0;
    int unsigned n_pop = 0;
    logic [15:0] sb_q[$];
    logic [15:0] sb_exp;

    always #5 clk = ~clk;

    assign imem_rdata   = imem_addr;
    assign b_imem_rdata = b_imem_addr;

    fetch_stage #(
        .PC_W     (16),
        .INST_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ready_i     (ready),
        .imem_rdata_i     (imem_rdata),
        .stall_i          (stall),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .if_valid_o       (if_valid),
        .if_inst_o        (if_inst),
        .if_opcode_o      (if_opcode),
        .if_pc_plus1_o    (if_pc_plus1)
    );

    fetch_stage #(
        .PC_W     (16),
        .INST_W   (16),
        .RESET_PC (16'hFFFF)
    ) dut_wrap (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_o       (b_imem_req),
        .imem_addr_o      (b_imem_addr),
        .imem_ready_i     (1'b1),
        .imem_rdata_i     (b_imem_rdata),
        .stall_i          (1'b0),
        .redirect_valid_i (1'b0),
        .redirect_pc_i    (16'h0000),
        .if_valid_o       (b_if_valid),
        .if_inst_o        (b_if_inst),
        .if_opcode_o      (b_if_opcode),
        .if_pc_plus1_o    (b_if_pc_plus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart(input logic [15:0] start, input int n);
        sb_q.delete();
        n_pop = 0;
        for (int i = 0; i < n; i++) sb_q.push_back(16'(start + 16'(i)));
    endtask

    always @(negedge clk) begin
        if (!rst && !stall && if_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                sb_exp = sb_q.pop_front();
                n_pop++;
                check_eq("sb_inst", 32'(if_inst), 32'(sb_exp));
                check_eq("sb_pc_plus1", 32'(if_pc_plus1), 32'(16'(sb_exp + 16'd1)));
                check_eq("sb_opcode", 32'(if_opcode), 32'(sb_exp[15:12]));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        ready    = 1'b1;
        stall    = 1'b0;
        redir    = 1'b0;
        redir_pc = 16'h0000;
        sb_restart(16'h0000, 10);
        tick();
        tick();
        // Reset state
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(if_valid), 32'd0);
        check_eq("rst_inst", 32'(if_inst), 32'd0);
        check_eq("rst_pc_plus1", 32'(if_pc_plus1), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;

        // 1: one bubble after reset, then a live instruction every cycle
        tick();
        check_eq("t1_valid_c1", 32'(if_valid), 32'd0);
        check_eq("t1_req_c1", 32'(imem_req), 32'd1);
        check_eq("t1_addr_c1", 32'(imem_addr), 32'd0);
        tick();
        check_eq("t1_valid_c2", 32'(if_valid), 32'd1);
        // 5: RESET_PC wraps
        check_eq("t5_inst", 32'(b_if_inst), 32'h0000_FFFF);
        check_eq("t5_pc_plus1", 32'(b_if_pc_plus1), 32'd0);
        check_eq("t5_opcode", 32'(b_if_opcode), 32'hF);
        check_eq("t5_addr2", 32'(b_imem_addr), 32'd0);
        tick();
        tick();

        // 2: stall 3 cycles with IF/ID = inst2
        check_eq("t2_inst2", 32'(if_inst), 32'd2);
        stall = 1'b1;
        check_eq("t2_req_s1", 32'(imem_req), 32'd1);
        tick();
        check_eq("t2_req_s2", 32'(imem_req), 32'd0);
        check_eq("t2_hold_s2", 32'(if_inst), 32'd2);
        check_eq("t2_addr_s2", 32'(imem_addr), 32'd4);
        tick();
        check_eq("t2_req_s3", 32'(imem_req), 32'd0);
        check_eq("t2_hold_s3", 32'(if_inst), 32'd2);
        tick();
        stall = 1'b0;
        check_eq("t2_req_rel", 32'(imem_req), 32'd0);
        tick();
        check_eq("t2_inst3", 32'(if_inst), 32'd3);
        check_eq("t2_req_back", 32'(imem_req), 32'd1);
        check_eq("t2_addr_back", 32'(imem_addr), 32'd4);
        tick();

        // 3: ready low at addr 5, redirect to 0x40 -> drop stale word
        ready = 1'b0;
        tick();
        check_eq("t3_bubble", 32'(if_valid), 32'd0);
        check_eq("t3_addr5", 32'(imem_addr), 32'd5);
        check_eq("t3_pops", n_pop, 32'd5);
        redir    = 1'b1;
        redir_pc = 16'h0040;
        sb_restart(16'h0040, 10);
        tick();
        redir = 1'b0;
        check_eq("t3_drop_req", 32'(imem_req), 32'd1);
        check_eq("t3_drop_addr", 32'(imem_addr), 32'd5);
        check_eq("t3_drop_valid", 32'(if_valid), 32'd0);
        tick();
        check_eq("t3_drop_valid2", 32'(if_valid), 32'd0);
        ready = 1'b1;
        tick();
        check_eq("t3_addr40", 32'(imem_addr), 32'h40);
        check_eq("t3_req40", 32'(imem_req), 32'd1);
        check_eq("t3_valid_still0", 32'(if_valid), 32'd0);
        tick();
        check_eq("t3_valid40", 32'(if_valid), 32'd1);
        check_eq("t3_inst40", 32'(if_inst), 32'h40);

        // 4: redirect while stalled with the hold buffer full
        stall = 1'b1;
        tick();
        check_eq("t4_hold_req", 32'(imem_req), 32'd0);
        redir    = 1'b1;
        redir_pc = 16'h0040;
        sb_restart(16'h0040, 10);
        tick();
        redir = 1'b0;
        stall = 1'b0;
        check_eq("t4_valid0", 32'(if_valid), 32'd0);
        check_eq("t4_req", 32'(imem_req), 32'd1);
        check_eq("t4_addr", 32'(imem_addr), 32'h40);
        tick();
        check_eq("t4_inst40", 32'(if_inst), 32'h40);
        tick();
        tick();
        tick();
        check_eq("t4_pops", n_pop, 32'd3);

        // 6: reset with a request pending
        ready = 1'b0;
        tick();
        check_eq("t6_pending", 32'(imem_req), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("t6_req", 32'(imem_req), 32'd0);
        check_eq("t6_valid", 32'(if_valid), 32'd0);
        check_eq("t6_pc", 32'(imem_addr), 32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        sb_restart(16'h0000, 10);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t6_pops", n_pop, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
